// File: rtl/player_input_framer.sv
// player_input_framer
// Captures NIOS keycode reports and decodes them into held-key flags for Fireboy
// and Icegirl. The flags reach the player blocks only on the vertical-sync frame
// boundary. Jump presses become one-frame pulses. If no report arrives for
// TIMEOUT_FRAMES frames, all held keys are forced released.
//
// Ports:
//   Clk            50 MHz system clock
//   Reset_n        asynchronous active-low reset
//   frame_clk      frame clock (~VGA_VS), asynchronous; rising edge = new frame
//   keycode_in     four keycode slots {slot3..slot0}; 8'h00 = empty slot
//   report_strobe  one-Clk pulse, keycode_in holds a complete report
//   fireboy_*      frame-aligned left/right held flags and jump pulse
//   icegirl_*      frame-aligned left/right held flags and jump pulse
//   report_stale   high while the report timeout is in force
module player_input_framer #(
  parameter logic [7:0] FB_LEFT        = 8'h50,
  parameter logic [7:0] FB_RIGHT       = 8'h4F,
  parameter logic [7:0] FB_JUMP        = 8'h52,
  parameter logic [7:0] IG_LEFT        = 8'h04,
  parameter logic [7:0] IG_RIGHT       = 8'h07,
  parameter logic [7:0] IG_JUMP        = 8'h1A,
  parameter int         TIMEOUT_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [31:0] keycode_in,
  input  logic        report_strobe,
  output logic        fireboy_left,
  output logic        fireboy_right,
  output logic        fireboy_jump,
  output logic        icegirl_left,
  output logic        icegirl_right,
  output logic        icegirl_jump,
  output logic        report_stale
);

  localparam int             CW   = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT_FRAMES);

  // True if any of the four slots carries the code; duplicates count once.
  function automatic logic slot_hit(input logic [31:0] kc, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (kc[8*s +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  logic          fs1, fs2, fs_d;
  logic          frame_tick;
  logic          fl_q, fr_q, fj_q, il_q, ir_q, ij_q;
  logic          fl_n, fr_n, fj_n, il_n, ir_n, ij_n;
  logic          fj_pend_q, ij_pend_q, fj_pend_n, ij_pend_n;
  logic          fj_edge, ij_edge;
  logic [CW-1:0] stale_cnt, stale_cnt_n;
  logic          timeout;

  // Tick is high in the cycle after the second synchronizer stage sees the rise,
  // so outputs move on the 3rd Clk edge after frame_clk rises.
  assign frame_tick = fs2 & ~fs_d;

  always_comb begin
    fl_n = fl_q;
    fr_n = fr_q;
    fj_n = fj_q;
    il_n = il_q;
    ir_n = ir_q;
    ij_n = ij_q;
    if (report_strobe) begin
      fl_n = slot_hit(keycode_in, FB_LEFT);
      fr_n = slot_hit(keycode_in, FB_RIGHT);
      fj_n = slot_hit(keycode_in, FB_JUMP);
      il_n = slot_hit(keycode_in, IG_LEFT);
      ir_n = slot_hit(keycode_in, IG_RIGHT);
      ij_n = slot_hit(keycode_in, IG_JUMP);
    end
    fj_edge = report_strobe & fj_n & ~fj_q;
    ij_edge = report_strobe & ij_n & ~ij_q;

    // A strobe always wins over the frame increment.
    stale_cnt_n = stale_cnt;
    if (report_strobe)
      stale_cnt_n = '0;
    else if (frame_tick && stale_cnt != TMAX)
      stale_cnt_n = stale_cnt + CW'(1);

    timeout = frame_tick & (stale_cnt_n == TMAX);
    if (timeout) begin
      fl_n    = 1'b0;
      fr_n    = 1'b0;
      fj_n    = 1'b0;
      il_n    = 1'b0;
      ir_n    = 1'b0;
      ij_n    = 1'b0;
      fj_edge = 1'b0;
      ij_edge = 1'b0;
    end

    // Pending jumps are consumed by every tick, including a timeout tick.
    fj_pend_n = frame_tick ? 1'b0 : (fj_pend_q | fj_edge);
    ij_pend_n = frame_tick ? 1'b0 : (ij_pend_q | ij_edge);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs1           <= 1'b0;
      fs2           <= 1'b0;
      fs_d          <= 1'b0;
      fl_q          <= 1'b0;
      fr_q          <= 1'b0;
      fj_q          <= 1'b0;
      il_q          <= 1'b0;
      ir_q          <= 1'b0;
      ij_q          <= 1'b0;
      fj_pend_q     <= 1'b0;
      ij_pend_q     <= 1'b0;
      stale_cnt     <= '0;
      fireboy_left  <= 1'b0;
      fireboy_right <= 1'b0;
      fireboy_jump  <= 1'b0;
      icegirl_left  <= 1'b0;
      icegirl_right <= 1'b0;
      icegirl_jump  <= 1'b0;
      report_stale  <= 1'b0;
    end else begin
      fs1          <= frame_clk;
      fs2          <= fs1;
      fs_d         <= fs2;
      fl_q         <= fl_n;
      fr_q         <= fr_n;
      fj_q         <= fj_n;
      il_q         <= il_n;
      ir_q         <= ir_n;
      ij_q         <= ij_n;
      fj_pend_q    <= fj_pend_n;
      ij_pend_q    <= ij_pend_n;
      stale_cnt    <= stale_cnt_n;
      report_stale <= (stale_cnt_n == TMAX);
      if (frame_tick) begin
        // Opposing directions cancel to 0/0.
        fireboy_left  <= fl_n & ~fr_n;
        fireboy_right <= fr_n & ~fl_n;
        fireboy_jump  <= fj_pend_q | fj_edge;
        icegirl_left  <= il_n & ~ir_n;
        icegirl_right <= ir_n & ~il_n;
        icegirl_jump  <= ij_pend_q | ij_edge;
        if (timeout) begin
          fireboy_jump <= 1'b0;
          icegirl_jump <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_player_input_framer.sv
// Self-checking bench for player_input_framer: directed scenarios plus a
// randomized run, all checked against a report/frame level reference model.
module tb_player_input_framer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic [31:0] keycode_in;
  logic        report_strobe;
  logic        fireboy_left, fireboy_right, fireboy_jump;
  logic        icegirl_left, icegirl_right, icegirl_jump;
  logic        report_stale;

  int tests = 0;
  int fails = 0;

  player_input_framer dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .keycode_in(keycode_in), .report_strobe(report_strobe),
    .fireboy_left(fireboy_left), .fireboy_right(fireboy_right), .fireboy_jump(fireboy_jump),
    .icegirl_left(icegirl_left), .icegirl_right(icegirl_right), .icegirl_jump(icegirl_jump),
    .report_stale(report_stale)
  );

  always #10 Clk = ~Clk;

  wire [6:0] outs = {fireboy_left, fireboy_right, fireboy_jump,
                     icegirl_left, icegirl_right, icegirl_jump, report_stale};

  // Reference model: which keys the last report holds, which jumps await a
  // frame, frames since the last report, and the outputs shown this frame.
  bit m_fl, m_fr, m_fj, m_il, m_ir, m_ij;
  bit m_pf, m_pi;
  int m_cnt;
  bit [5:0] m_out;

  function automatic bit has_code(input logic [31:0] kc, input logic [7:0] code);
    for (int s = 0; s < 4; s++) if (kc[8*s +: 8] == code) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] exp_vec();
    return {m_out, (m_cnt == 30)};
  endfunction

  task automatic model_reset();
    {m_fl, m_fr, m_fj, m_il, m_ir, m_ij, m_pf, m_pi} = '0;
    m_cnt = 0;
    m_out = '0;
  endtask

  task automatic model_report(input logic [31:0] kc);
    bit nfj, nij;
    nfj = has_code(kc, 8'h52);
    nij = has_code(kc, 8'h1A);
    if (nfj && !m_fj) m_pf = 1'b1;
    if (nij && !m_ij) m_pi = 1'b1;
    m_fl = has_code(kc, 8'h50);
    m_fr = has_code(kc, 8'h4F);
    m_fj = nfj;
    m_il = has_code(kc, 8'h04);
    m_ir = has_code(kc, 8'h07);
    m_ij = nij;
    m_cnt = 0;
  endtask

  task automatic model_tick();
    if (m_cnt < 30) m_cnt++;
    if (m_cnt == 30) {m_fl, m_fr, m_fj, m_il, m_ir, m_ij, m_pf, m_pi} = '0;
    m_out = {m_fl & ~m_fr, m_fr & ~m_fl, m_pf, m_il & ~m_ir, m_ir & ~m_il, m_pi};
    m_pf = 1'b0;
    m_pi = 1'b0;
  endtask

  // Stimulus drivers (no checking inside).
  task automatic strobe(input logic [31:0] kc);
    @(posedge Clk); #1;
    keycode_in = kc;
    report_strobe = 1'b1;
    @(posedge Clk); #1;
    report_strobe = 1'b0;
    model_report(kc);
  endtask

  // One frame_clk pulse. pre = outputs just before the tick edge, post = just
  // after it. Optionally strobes a report on the tick cycle itself.
  task automatic frame_step(input bit with_strobe, input logic [31:0] kc,
                            output logic [6:0] pre, output logic [6:0] post);
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    pre = outs;
    if (with_strobe) begin
      keycode_in = kc;
      report_strobe = 1'b1;
      model_report(kc);
    end
    @(posedge Clk); #1;
    report_strobe = 1'b0;
    model_tick();
    post = outs;
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    frame_clk = 1'b0;
    report_strobe = 1'b0;
    keycode_in = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    tests++;
    if (outs !== 7'b0) begin fails++; $display("FAIL reset_outs got=%b exp=%b", outs, 7'b0); end
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic test_first_tick();
    logic [6:0] pre, post, e0;
    strobe(32'h0000_0050);
    tests++;
    if (outs !== 7'b0) begin fails++; $display("FAIL strobe_no_output_change got=%b exp=%b", outs, 7'b0); end
    e0 = exp_vec();
    frame_step(1'b0, '0, pre, post);
    tests++;
    if (pre !== e0) begin fails++; $display("FAIL pre_tick_stable got=%b exp=%b", pre, e0); end
    tests++;
    if (post !== exp_vec()) begin fails++; $display("FAIL first_tick got=%b exp=%b", post, exp_vec()); end
    tests++;
    if (fireboy_left !== 1'b1) begin fails++; $display("FAIL first_tick_fb_left got=%b exp=1", fireboy_left); end
  endtask

  task automatic test_cancel();
    logic [6:0] pre, post;
    strobe(32'h004F_0050);
    frame_step(1'b0, '0, pre, post);
    tests++;
    if (post[6:5] !== 2'b00 || post !== exp_vec()) begin
      fails++; $display("FAIL cancel_lr got=%b exp=%b", post, exp_vec());
    end
  endtask

  task automatic test_jump_held();
    logic [6:0] pre, post;
    strobe(32'h0000_001A);
    for (int f = 0; f < 4; f++) begin
      frame_step(1'b0, '0, pre, post);
      tests++;
      if (post[1] !== (f == 0) || post !== exp_vec()) begin
        fails++; $display("FAIL jump_held_frame%0d got=%b exp=%b", f, post, exp_vec());
      end
      strobe(32'h0000_001A);
    end
    strobe(32'h0000_0000);
  endtask

  task automatic test_jump_tap();
    logic [6:0] pre, post;
    strobe(32'h0000_0052);
    strobe(32'h0000_0000);
    frame_step(1'b0, '0, pre, post);
    tests++;
    if (post[4] !== 1'b1 || post !== exp_vec()) begin
      fails++; $display("FAIL jump_tap got=%b exp=%b", post, exp_vec());
    end
    frame_step(1'b0, '0, pre, post);
    tests++;
    if (post[4] !== 1'b0 || post !== exp_vec()) begin
      fails++; $display("FAIL jump_tap_clear got=%b exp=%b", post, exp_vec());
    end
  endtask

  task automatic test_timeout();
    logic [6:0] pre, post;
    strobe(32'h0750_0000);
    for (int t = 1; t <= 31; t++) begin
      frame_step(1'b0, '0, pre, post);
      tests++;
      if (t < 30) begin
        if (post[6] !== 1'b1 || post[2] !== 1'b1 || post[0] !== 1'b0 || post !== exp_vec()) begin
          fails++; $display("FAIL timeout_held_tick%0d got=%b exp=%b", t, post, exp_vec());
        end
      end else begin
        if (post !== 7'b000_0001 || post !== exp_vec()) begin
          fails++; $display("FAIL timeout_tick%0d got=%b exp=%b", t, post, 7'b000_0001);
        end
      end
    end
    strobe(32'h0000_0000);
    tests++;
    if (report_stale !== 1'b0 || outs !== exp_vec()) begin
      fails++; $display("FAIL stale_clear got=%b exp=%b", outs, exp_vec());
    end
  endtask

  task automatic test_coincident();
    logic [6:0] pre, post;
    strobe(32'h0000_0000);
    frame_step(1'b1, 32'h0000_001A, pre, post);
    tests++;
    if (post[1] !== 1'b1 || post !== exp_vec()) begin
      fails++; $display("FAIL coincident_jump got=%b exp=%b", post, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] pre, post;
    strobe(32'h0000_0050);
    frame_step(1'b0, '0, pre, post);
    strobe(32'h0000_0052);
    @(posedge Clk); #5;
    Reset_n = 1'b0;
    #1;
    tests++;
    if (outs !== 7'b0) begin fails++; $display("FAIL reset_mid_async got=%b exp=%b", outs, 7'b0); end
    model_reset();
    @(posedge Clk); #3;
    Reset_n = 1'b1;
    frame_step(1'b0, '0, pre, post);
    tests++;
    if (post !== 7'b0 || post !== exp_vec()) begin
      fails++; $display("FAIL reset_no_jump got=%b exp=%b", post, 7'b0);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [0:7];
    logic [31:0] kc;
    logic [6:0] pre, post, e0;
    pool = '{8'h00, 8'h50, 8'h4F, 8'h52, 8'h04, 8'h07, 8'h1A, 8'h33};
    for (int it = 0; it < 150; it++) begin
      kc = '0;
      for (int s = 0; s < 4; s++) kc[8*s +: 8] = pool[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0, 1: begin
          strobe(kc);
          tests++;
          if (outs !== exp_vec()) begin fails++; $display("FAIL rand_strobe it=%0d got=%b exp=%b", it, outs, exp_vec()); end
        end
        2: begin
          e0 = exp_vec();
          frame_step(1'b0, '0, pre, post);
          tests++;
          if (pre !== e0 || post !== exp_vec()) begin
            fails++; $display("FAIL rand_tick it=%0d pre=%b/%b got=%b exp=%b", it, pre, e0, post, exp_vec());
          end
        end
        default: begin
          frame_step(1'b1, kc, pre, post);
          tests++;
          if (post !== exp_vec()) begin fails++; $display("FAIL rand_coinc it=%0d got=%b exp=%b", it, post, exp_vec()); end
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_cancel();
    test_jump_held();
    test_jump_tap();
    test_timeout();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
